// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes and select decode.
package usr_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_HOLD = 3'b000;
   localparam mode_t MODE_LOAD = 3'b001;
   localparam mode_t MODE_SHR  = 3'b010;
   localparam mode_t MODE_SHL  = 3'b011;
   localparam mode_t MODE_ROR  = 3'b100;
   localparam mode_t MODE_ROL  = 3'b101;
   localparam mode_t MODE_ASR  = 3'b110;
   localparam mode_t MODE_SCLR = 3'b111;

   localparam int unsigned NUM_MODES = 8;

   // One-hot operation select, indexed by mode code
   typedef logic [NUM_MODES-1:0] sel_t;

   function automatic sel_t decode_mode(input mode_t m);
      sel_t s;
      s    = '0;
      s[m] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register: async clear/preset flop plus 8:1 next-state mux.
module usr_cell
   import usr_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic pre,
   input  logic en,
   input  sel_t sel,
   input  logic d,
   input  logic left,
   input  logic right,
   output logic q
);

   logic nxt;
   logic set_n;

   // Preset is masked while clear is low, so releasing clear with preset still low
   // produces a falling edge here and the bit sets without a clock.
   assign set_n = pre | ~clr;

   // Next-state select; left feeds right-moving ops, right feeds left-moving ops
   always_comb begin
      nxt = q;
      if (en) begin
         unique case (1'b1)
            sel[MODE_HOLD]: nxt = q;
            sel[MODE_LOAD]: nxt = d;
            sel[MODE_SHR]:  nxt = left;
            sel[MODE_SHL]:  nxt = right;
            sel[MODE_ROR]:  nxt = left;
            sel[MODE_ROL]:  nxt = right;
            sel[MODE_ASR]:  nxt = left;
            sel[MODE_SCLR]: nxt = 1'b0;
            default:        nxt = q;
         endcase
      end
   end

   // State flop: clear beats preset, both beat the clock
   always_ff @(posedge clk or negedge clr or negedge set_n) begin
      if (!clr) begin
         q <= 1'b0;
      end else if (!set_n) begin
         q <= 1'b1;
      end else begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: mode decode, edge-bit neighbour logic, per-bit cells.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             pre,
   input  logic             en,
   input  mode_t            mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sr_in,
   input  logic             sl_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             sr_out,
   output logic             sl_out
);

   sel_t             sel;
   logic [WIDTH-1:0] left;
   logic [WIDTH-1:0] right;
   logic             msb_in;
   logic             lsb_in;

   assign sel = decode_mode(mode);

   // Bit entering the MSB on right-moving ops: serial in, wrap, or sign copy
   always_comb begin
      msb_in = sr_in;
      if (mode == MODE_ROR) begin
         msb_in = q[0];
      end else if (mode == MODE_ASR) begin
         msb_in = q[WIDTH-1];
      end
   end

   // Bit entering the LSB on left-moving ops: serial in or wrap
   always_comb begin
      lsb_in = sl_in;
      if (mode == MODE_ROL) begin
         lsb_in = q[WIDTH-1];
      end
   end

   assign left  = {msb_in, q[WIDTH-1:1]};
   assign right = {q[WIDTH-2:0], lsb_in};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      usr_cell u_cell (
         .clk   (clk),
         .clr   (clr),
         .pre   (pre),
         .en    (en),
         .sel   (sel),
         .d     (d[i]),
         .left  (left[i]),
         .right (right[i]),
         .q     (q[i])
      );
   end

   assign q_bar  = ~q;
   assign sr_out = q[0];
   assign sl_out = q[WIDTH-1];

endmodule
